// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg: state encoding and timing constants shared by the
// comparator arbiter. Supplies default HASH_NUM_MSB / HASH_COUNT_MSB /
// NUM_HASHES when the shared header has not defined them.

`ifndef HASH_NUM_MSB
`define HASH_NUM_MSB 7
`endif
`ifndef HASH_COUNT_MSB
`define HASH_COUNT_MSB 8
`endif
`ifndef NUM_HASHES
`define NUM_HASHES (1 << (`HASH_NUM_MSB + 1))
`endif

package cmp_arbiter_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StStart,
        StSettle,
        StWait,
        StResp
    } arb_state_e;

    // Cycles after start before comparator found/finished can be trusted.
    localparam int unsigned SETTLE_CYCLES = 2;

    // Long enough for any scan left running by a previous owner to finish.
    localparam int unsigned HOLDOFF   = (1 << (`HASH_NUM_MSB + 1)) + 4;
    localparam int unsigned HOLDOFF_W = $clog2(HOLDOFF + 1);

endpackage

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: requester-side bus of the comparator arbiter.
// master = requesters/result consumers, slave = the arbiter.

interface cmp_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_MSB = (N_REQ > 1) ? $clog2(N_REQ) - 1 : 0
);
    logic [N_REQ-1:0]       req_valid;
    logic [32*N_REQ-1:0]    req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   resp_valid;
    logic [ID_MSB:0]        resp_id;
    logic                   resp_found;
    logic [`HASH_NUM_MSB:0] resp_hash_num;
    logic                   resp_err;

    modport master (
        output req_valid, req_data,
        input  req_ready, resp_valid, resp_id, resp_found, resp_hash_num, resp_err
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, resp_valid, resp_id, resp_found, resp_hash_num, resp_err
    );
endinterface

// File: rtl/cmp_arbiter_rr_select.sv
// cmp_arbiter_rr_select: combinational cyclic priority picker. Returns the
// first set bit of req searching upward from ptr, wrapping at N_REQ.

module cmp_arbiter_rr_select #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ID_MSB = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_MSB:0]  ptr,
    output logic [ID_MSB:0]  grant_idx,
    output logic             any
);

    // Scan all positions starting at ptr; first hit wins.
    always_comb begin
        int unsigned j;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr) + i) % N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant_idx = j[ID_MSB:0];
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one comparator between N_REQ requesters in round-robin
// order, sequences start/settle/wait and returns the result with the
// requester id. Optional feature macro: CMP_TIMEOUT_EN (WAIT timeout with
// resp_err and a re-flush through INIT).

module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ID_MSB         = (N_REQ > 1) ? $clog2(N_REQ) - 1 : 0,
    parameter int unsigned TIMEOUT_MARGIN = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    cmp_arbiter_if.slave             req_bus,
    input  logic                     cfg_busy,
    input  logic [`HASH_COUNT_MSB:0] hash_count,
    output logic                     busy,
    output logic [31:0]              cmp_data,
    output logic                     cmp_start,
    input  logic                     cmp_found,
    input  logic                     cmp_finished,
    input  logic [`HASH_NUM_MSB:0]   cmp_hash_num
);

    localparam int unsigned ID_W = ID_MSB + 1;

    arb_state_e             state_q, state_d;
    logic [ID_MSB:0]        rr_ptr_q, cur_id_q, grant_idx;
    logic                   grant_any, grant_go;
    logic [HOLDOFF_W-1:0]   holdoff_q;
    logic [1:0]             settle_q;
    logic [31:0]            cmp_data_q;
    logic                   resp_found_q;
    logic [`HASH_NUM_MSB:0] resp_hash_num_q;
    logic                   timeout;
    logic                   resp_err;

    cmp_arbiter_rr_select #(
        .N_REQ  (N_REQ),
        .ID_MSB (ID_MSB)
    ) u_rr_select (
        .req       (req_bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign grant_go = (state_q == StIdle) && !cfg_busy && grant_any;

`ifdef CMP_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_limit;
    logic        resp_err_q;

    assign wait_limit = 16'(hash_count) + 16'(TIMEOUT_MARGIN);
    assign timeout    = (wait_cnt_q == wait_limit - 16'd1);
    assign resp_err   = resp_err_q;

    // WAIT-cycle counter and sticky error flag for the current grant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (state_q == StSettle) begin
                wait_cnt_q <= '0;
            end else if (state_q == StWait) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            if (grant_go) begin
                resp_err_q <= 1'b0;
            end else if (state_q == StWait && !cmp_found && !cmp_finished && timeout) begin
                resp_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_margin;

    assign unused_timeout_margin = ^TIMEOUT_MARGIN;
    assign timeout               = 1'b0;
    assign resp_err              = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   if (holdoff_q == '0) state_d = StIdle;
            StIdle:   if (grant_go) state_d = (hash_count == '0) ? StResp : StStart;
            StStart:  state_d = StSettle;
            StSettle: if (settle_q == 2'(SETTLE_CYCLES - 1)) state_d = StWait;
            StWait:   if (cmp_found || cmp_finished || timeout) state_d = StResp;
            StResp:   state_d = resp_err ? StInit : StIdle;
            default:  state_d = StInit;
        endcase
    end

    // Moore outputs plus the combinational accept pulse in IDLE.
    always_comb begin
        req_bus.req_ready = '0;
        if (grant_go) begin
            req_bus.req_ready[grant_idx] = 1'b1;
        end
        cmp_start          = (state_q == StStart);
        req_bus.resp_valid = (state_q == StResp);
        busy               = (state_q != StIdle) && (state_q != StInit);
    end

    // Datapath: holdoff/settle counters, grant latching, result capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            holdoff_q       <= HOLDOFF_W'(HOLDOFF);
            settle_q        <= '0;
            rr_ptr_q        <= '0;
            cur_id_q        <= '0;
            cmp_data_q      <= '0;
            resp_found_q    <= 1'b0;
            resp_hash_num_q <= '0;
        end else begin
            if (state_q == StInit && holdoff_q != '0) begin
                holdoff_q <= holdoff_q - HOLDOFF_W'(1);
            end else if (state_q == StResp && resp_err) begin
                holdoff_q <= HOLDOFF_W'(HOLDOFF);
            end

            settle_q <= (state_q == StSettle) ? settle_q + 2'd1 : 2'd0;

            if (grant_go) begin
                cmp_data_q      <= req_bus.req_data[32*grant_idx +: 32];
                cur_id_q        <= grant_idx;
                rr_ptr_q        <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                resp_found_q    <= 1'b0;
                resp_hash_num_q <= '0;
            end

            // Found wins over finished in the same cycle.
            if (state_q == StWait) begin
                if (cmp_found) begin
                    resp_found_q    <= 1'b1;
                    resp_hash_num_q <= cmp_hash_num;
                end else if (cmp_finished || timeout) begin
                    resp_found_q    <= 1'b0;
                end
            end
        end
    end

    assign cmp_data              = cmp_data_q;
    assign req_bus.resp_id       = cur_id_q;
    assign req_bus.resp_found    = resp_found_q;
    assign req_bus.resp_hash_num = resp_hash_num_q;
    assign req_bus.resp_err      = resp_err;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed bench with a behavioural comparator and a grant/
// response scoreboard for cmp_arbiter. Honours CMP_TIMEOUT_EN.

module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;

    localparam int unsigned N_REQ          = 4;
    localparam int unsigned ID_MSB         = 1;
    localparam int unsigned TIMEOUT_MARGIN = 16;

    typedef struct {
        int                     id;
        logic                   found;
        logic [`HASH_NUM_MSB:0] hash;
        logic                   err;
        int                     lat;
        logic                   start;
        logic [31:0]            data;
        int                     gcyc;
    } exp_t;

    logic                     CLK = 1'b0;
    logic                     RST_N;
    logic                     cfg_busy;
    logic [`HASH_COUNT_MSB:0] hash_count;
    logic                     busy;
    logic [31:0]              cmp_data;
    logic                     cmp_start;
    logic                     cmp_found = 1'b0;
    logic                     cmp_finished = 1'b0;
    logic [`HASH_NUM_MSB:0]   cmp_hash_num = '0;

    cmp_arbiter_if #(.N_REQ(N_REQ), .ID_MSB(ID_MSB)) bus ();

    cmp_arbiter #(
        .N_REQ          (N_REQ),
        .ID_MSB         (ID_MSB),
        .TIMEOUT_MARGIN (TIMEOUT_MARGIN)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .req_bus      (bus.slave),
        .cfg_busy     (cfg_busy),
        .hash_count   (hash_count),
        .busy         (busy),
        .cmp_data     (cmp_data),
        .cmp_start    (cmp_start),
        .cmp_found    (cmp_found),
        .cmp_finished (cmp_finished),
        .cmp_hash_num (cmp_hash_num)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   grant_cnt = 0;
    int   resp_cnt = 0;
    int   starts_open = 0;
    int   m_ptr = 0;
    exp_t sb[$];
    int   grant_log[$];

    // Comparator model knobs.
    logic m_match_en = 1'b0;
    logic m_stuck = 1'b0;
    int   m_match_idx = 5;
    logic m_scanning = 1'b0;
    logic m_clr = 1'b0;
    int   m_idx = 0;

    // Behavioural comparator: clears outputs one cycle after start, then
    // scans one index per cycle.
    always @(posedge CLK) begin
        if (cmp_start === 1'b1) begin
            m_scanning <= 1'b1;
            m_clr      <= 1'b1;
            m_idx      <= 0;
        end else if (m_clr) begin
            m_clr        <= 1'b0;
            cmp_found    <= 1'b0;
            cmp_finished <= 1'b0;
        end else if (m_stuck) begin
            m_scanning <= 1'b0;
        end else if (m_scanning) begin
            if (m_match_en && m_idx == m_match_idx) begin
                cmp_found    <= 1'b1;
                cmp_hash_num <= m_idx[`HASH_NUM_MSB:0];
                m_scanning   <= 1'b0;
            end else if (m_idx == int'(hash_count) - 1) begin
                cmp_finished <= 1'b1;
                m_scanning   <= 1'b0;
            end
            m_idx <= m_idx + 1;
        end
    end

    task automatic chk(input logic [63:0] got, input logic [63:0] want, input string tag);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int exp_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int i = 0; i < N_REQ; i++) begin
            if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_grants(input int target, input int budget, input string tag);
        int left;
        left = budget;
        while (grant_cnt < target && left > 0) begin
            tick(1);
            left--;
        end
        chk(grant_cnt >= target, 1, tag);
    endtask

    task automatic wait_resps(input int target, input int budget, input string tag);
        int left;
        left = budget;
        while (resp_cnt < target && left > 0) begin
            tick(1);
            left--;
        end
        chk(resp_cnt >= target, 1, tag);
    endtask

    task automatic check_quiet(input string tag);
        chk(busy, 0, {tag, "_busy"});
        chk(cmp_start, 0, {tag, "_cmp_start"});
        chk(cmp_data, 0, {tag, "_cmp_data"});
        chk(bus.req_ready, 0, {tag, "_req_ready"});
        chk(bus.resp_valid, 0, {tag, "_resp_valid"});
        chk(bus.resp_id, 0, {tag, "_resp_id"});
        chk(bus.resp_found, 0, {tag, "_resp_found"});
        chk(bus.resp_hash_num, 0, {tag, "_resp_hash"});
        chk(bus.resp_err, 0, {tag, "_resp_err"});
    endtask

    // Monitor: builds expectations at each grant, checks starts and responses.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (bus.req_ready !== '0) begin
                    g = exp_pick(bus.req_valid, m_ptr);
                    chk(bus.req_ready, (g < 0) ? 64'd0 : (64'd1 << g), "grant_vec");
                    if (g >= 0) begin
                        m_ptr   = (g + 1) % N_REQ;
                        e.id    = g;
                        e.data  = bus.req_data[32*g +: 32];
                        e.start = (hash_count != '0);
                        e.found = 1'b0;
                        e.hash  = '0;
                        e.err   = 1'b0;
                        e.gcyc  = cyc;
                        if (hash_count == '0) begin
                            e.lat = 1;
                        end else if (m_stuck) begin
                            e.err = 1'b1;
                            e.lat = 4 + int'(hash_count) + TIMEOUT_MARGIN;
                        end else if (m_match_en && m_match_idx < int'(hash_count)) begin
                            e.found = 1'b1;
                            e.hash  = m_match_idx[`HASH_NUM_MSB:0];
                            e.lat   = 5 + m_match_idx;
                        end else begin
                            e.lat = 4 + int'(hash_count);
                        end
                        sb.push_back(e);
                        grant_log.push_back(g);
                    end
                    grant_cnt++;
                end
                if (cmp_start === 1'b1) begin
                    chk(starts_open, 0, "single_start");
                    starts_open++;
                    if (sb.size() > 0) chk(cmp_data, sb[0].data, "cmp_data_at_start");
                end
                if (bus.resp_valid === 1'b1) begin
                    chk(sb.size() > 0, 1, "resp_expected");
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk(bus.resp_id, e.id, "resp_id");
                        chk(bus.resp_found, e.found, "resp_found");
                        if (e.found) chk(bus.resp_hash_num, e.hash, "resp_hash_num");
                        chk(bus.resp_err, e.err, "resp_err");
                        chk(cyc - e.gcyc, e.lat, "resp_latency");
                        chk(starts_open, e.start ? 1 : 0, "start_count");
                        chk(cmp_data, e.data, "cmp_data_at_resp");
                    end
                    starts_open = 0;
                    resp_cnt++;
                end
            end
        end
    end

    initial begin
        int rr_exp [5];
        int g0;
        rr_exp = '{0, 1, 2, 3, 0};

        RST_N         = 1'b0;
        cfg_busy      = 1'b0;
        hash_count    = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        #1;
        check_quiet("reset");
        tick(3);

        // Single request, match at index 5 of 8; held off until INIT ends.
        RST_N                = 1'b1;
        hash_count           = 8;
        m_match_en           = 1'b1;
        m_match_idx          = 5;
        bus.req_data[31:0]   = 32'hDEADBEEF;
        bus.req_valid        = 4'b0001;
        tick(HOLDOFF - 8);
        chk(grant_cnt, 0, "no_grant_in_init");
        chk(busy, 0, "busy_in_init");
        wait_grants(1, 40, "t1_grant");
        bus.req_valid = '0;
        wait_resps(1, 40, "t1_resp");
        chk(grant_cnt, 1, "t1_single_ready");

        // No match, hash_count 3, stale found from previous compare.
        m_match_en           = 1'b0;
        hash_count           = 3;
        bus.req_data[127:96] = 32'h12345678;
        bus.req_valid        = 4'b1000;
        wait_grants(2, 10, "t3_grant");
        bus.req_valid = '0;
        wait_resps(2, 30, "t3_resp");

        // All requesters continuously valid.
        hash_count   = 2;
        bus.req_data = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        bus.req_valid = 4'b1111;
        wait_grants(7, 100, "rr_grants");
        bus.req_valid = '0;
        wait_resps(7, 30, "rr_resps");
        for (int i = 0; i < 5; i++) chk(grant_log[2 + i], rr_exp[i], "rr_order");

        // hash_count 0: immediate response, no start.
        hash_count        = 0;
        bus.req_data[95:64] = 32'hCAFEF00D;
        bus.req_valid     = 4'b0100;
        wait_grants(8, 10, "hc0_grant");
        bus.req_valid = '0;
        chk(grant_log[7], 2, "hc0_grant_id");
        wait_resps(8, 5, "hc0_resp");

        // cfg_busy blocks grants; raising it mid-compare does not abort.
        hash_count    = 8;
        cfg_busy      = 1'b1;
        bus.req_data[31:0] = 32'h0BADBEEF;
        bus.req_valid = 4'b0001;
        tick(6);
        chk(grant_cnt, 8, "cfg_busy_blocks");
        cfg_busy = 1'b0;
        tick(1);
        chk(grant_cnt, 9, "grant_after_cfg_busy");
        bus.req_valid = '0;
        tick(4);
        chk(busy, 1, "busy_in_wait");
        cfg_busy = 1'b1;
        wait_resps(9, 40, "cfg_busy_resp");
        cfg_busy = 1'b0;

        // Reset during WAIT drops the request silently.
        m_stuck       = 1'b1;
        bus.req_valid = 4'b0010;
        wait_grants(10, 10, "rst_grant");
        bus.req_valid = '0;
        tick(6);
        chk(busy, 1, "busy_before_reset");
        RST_N = 1'b0;
        #1;
        check_quiet("reset_mid_wait");
        sb.delete();
        starts_open = 0;
        m_ptr       = 0;
        tick(2);
        RST_N   = 1'b1;
        m_stuck = 1'b0;
        tick(40);
        chk(resp_cnt, 9, "no_resp_after_reset");
        tick(HOLDOFF);

        // Pointer restarts at 0 after reset.
        hash_count    = 3;
        m_match_en    = 1'b1;
        m_match_idx   = 1;
        bus.req_valid = 4'b0110;
        wait_grants(11, 20, "post_rst_grant");
        bus.req_valid = '0;
        chk(grant_log[grant_log.size() - 1], 1, "post_rst_ptr");
        wait_resps(10, 30, "post_rst_resp");

`ifdef CMP_TIMEOUT_EN
        // Stuck comparator times out, then INIT holdoff before next grant.
        m_stuck       = 1'b1;
        m_match_en    = 1'b0;
        hash_count    = 4;
        bus.req_valid = 4'b1000;
        g0 = grant_cnt;
        wait_grants(g0 + 1, 10, "to_grant");
        bus.req_valid = '0;
        wait_resps(11, 60, "to_resp");
        chk(busy, 0, "init_after_timeout");
        bus.req_valid = 4'b0001;
        tick(20);
        chk(grant_cnt, g0 + 1, "holdoff_after_timeout");
        m_stuck    = 1'b0;
        hash_count = 2;
        wait_grants(g0 + 2, HOLDOFF + 20, "after_to_grant");
        bus.req_valid = '0;
        wait_resps(12, 30, "after_to_resp");
`else
        g0 = grant_cnt;
        chk(g0, 11, "total_grants");
`endif

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares the single `comparator` instance between N_REQ hash-computing units.
- Grants one 32-bit compare word at a time in round-robin order, drives the comparator's start/cmp_data, and sequences the comparator's settle latency.
- Returns found/hash_num with the requester ID.
- Sits between the compute cores' result outputs and `comparator`, alongside cmp_config.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_MSB, $clog2(N_REQ)-1 (min 0), MSB of requester ID.
- TIMEOUT_MARGIN, 16, extra cycles over hash_count before timeout (CMP_TIMEOUT_EN only).
- Widths of hash_num/hash_count come from the shared `HASH_NUM_MSB` and `HASH_COUNT_MSB` macros.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i holds a compare word
- req_data  in  32*N_REQ  word i at bits [32i+31:32i]
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
- cfg_busy  in  1  cmp_config is writing comparator memory; no new grants
- hash_count  in  HASH_COUNT_MSB+1  loaded hash count
- busy  out  1  state != IDLE and state != INIT
- cmp_data  out  32  to comparator, held for the whole comparison
- cmp_start  out  1  to comparator start
- cmp_found  in  1  from comparator
- cmp_finished  in  1  from comparator
- cmp_hash_num  in  HASH_NUM_MSB+1  from comparator
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  ID_MSB+1  requester of the result
- resp_found  out  1  match found
- resp_hash_num  out  HASH_NUM_MSB+1  matching index, valid when resp_found
- resp_err  out  1  timeout, 0 unless CMP_TIMEOUT_EN

Behaviour:
- Reset (RST_N low, async):
  - All outputs 0.
  - rr_ptr=0, state=INIT, holdoff counter loaded with 2^(HASH_NUM_MSB+1)+4, which flushes any comparator scan left running.
  - Reset mid-operation drops the current request silently; no resp is issued.
- INIT: decrement holdoff counter; at 0 go to IDLE.
- IDLE:
  - If !cfg_busy and |req_valid, grant the first set bit searching cyclically from rr_ptr.
  - Latch its word into cmp_data and its index into cur_id; pulse req_ready[cur_id].
  - rr_ptr <= cur_id+1, wrapping to 0 at N_REQ.
  - If hash_count==0, go to RESP with found=0 (comparator not started). Otherwise go to START.
- START: cmp_start=1 for exactly one cycle, then go to SETTLE.
- SETTLE:
  - Wait 2 cycles; the comparator clears found/finished one cycle after start.
  - cmp_found/cmp_finished are ignored here. Then go to WAIT.
- WAIT:
  - If cmp_found: resp_found<=1, resp_hash_num<=cmp_hash_num, go to RESP.
  - Else if cmp_finished: resp_found<=0, go to RESP.
  - Found has priority when both are asserted in the same cycle.
- RESP: resp_valid=1 with resp_id=cur_id for one cycle, then go to IDLE.
- Timing:
  - Grant-to-resp latency = 4 + scan cycles.
  - The next grant comes no earlier than the cycle after RESP.
  - The hash_count==0 path takes grant + 1 cycle.
- cfg_busy rising mid-comparison does not abort; the comparison completes. cmp_config must check busy.
- cmp_data is stable from the grant through RESP.
- Requesters must hold req_valid/req_data until req_ready. Deasserting req_valid before req_ready is permitted; that request is not served.

Optional Feature:
- Macro: CMP_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit WAIT-cycle counter runs.
  - When the counter reaches hash_count+TIMEOUT_MARGIN without found/finished, go to RESP with resp_found=0 and resp_err=1.
  - The state then goes to INIT to flush the comparator.
- Without the macro: no counter; resp_err is tied 0 and WAIT can last indefinitely.

Decomposition:
- Shared package/header: state encodings (INIT, IDLE, START, SETTLE, WAIT, RESP), SETTLE_CYCLES=2, HOLDOFF constant; reuse `HASH_NUM_MSB`, `HASH_COUNT_MSB`, `NUM_HASHES`.
- One sub-module: rr_select, a combinational cyclic priority picker (req vector, ptr -> grant index, any).

Test Plan:
- Reset, then wait for holdoff; single req0 word=0xDEADBEEF; comparator model holds match at index 5 of hash_count=8 -> one req_ready[0] pulse, cmp_start 1 cycle, resp_valid with id=0, found=1, hash_num=5.
- All 4 requesters valid continuously -> grant order 0,1,2,3,0; each resp_id matches grant order; never two starts before one resp.
- No match, hash_count=3 -> resp found=0, err=0, resp 4+scan cycles after grant; stale found=1 from the previous compare held during SETTLE is ignored.
- hash_count=0 with req2 valid -> req_ready[2], resp found=0 one cycle later, cmp_start never asserted.
- cfg_busy=1 while req valid -> no grant; drop cfg_busy -> grant next cycle. Raise cfg_busy during WAIT -> compare completes normally.
- CMP_TIMEOUT_EN with comparator stuck (no found/finished), hash_count=4 -> resp_err=1 after 20 WAIT cycles, then INIT holdoff. RST_N pulse during WAIT -> all outputs 0 immediately, no resp_valid.
